// File: rtl/mprj2_power_sequencer.sv
// Power sequencer for user area 2: debounces the domain power-good, then releases
// isolation, the Wishbone path and the LA/IO path in stages, and tears them down in reverse.
module mprj2_power_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STAGE_CYCLES    = 4
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       pwr_good,
   input  logic       en_req,
   input  logic       fault_clr,
   output logic       mprj2_iso_n,
   output logic       mprj2_wb_en,
   output logic       mprj2_la_en,
   output logic       mprj2_ready,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_DEBOUNCE = 3'd1,
      S_ISO_REL  = 3'd2,
      S_WB_EN    = 3'd3,
      S_ON       = 3'd4,
      S_SHDN_LA  = 3'd5,
      S_SHDN_WB  = 3'd6,
      S_FAULT    = 3'd7
   } state_t;

   localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] STAGE_LAST = 8'(STAGE_CYCLES - 1);

   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   logic       pg_meta_reg, pg_sync_reg;
   logic       iso_n_reg, wb_en_reg, la_en_reg, ready_reg, fault_reg;
   logic       iso_n_next, wb_en_next, la_en_next, ready_next, fault_next;
   logic       deb_done, stage_done;

   assign deb_done   = (cnt_reg == DEB_LAST);
   assign stage_done = (cnt_reg == STAGE_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_OFF: begin
            if (en_req && pg_sync_reg)
               state_next = S_DEBOUNCE;
         end
         S_DEBOUNCE: begin
            if (!pg_sync_reg || !en_req)
               state_next = S_OFF;
            else if (deb_done)
               state_next = S_ISO_REL;
         end
         S_ISO_REL, S_WB_EN, S_ON: begin
            // Power loss outranks a simultaneous request drop.
            if (!pg_sync_reg)
               state_next = S_FAULT;
            else if (!en_req)
               state_next = S_SHDN_LA;
            else if (stage_done && state_reg == S_ISO_REL)
               state_next = S_WB_EN;
            else if (stage_done && state_reg == S_WB_EN)
               state_next = S_ON;
         end
         S_SHDN_LA: begin
            if (!pg_sync_reg)
               state_next = S_FAULT;
            else if (stage_done)
               state_next = S_SHDN_WB;
         end
         S_SHDN_WB: begin
            if (!pg_sync_reg)
               state_next = S_FAULT;
            else if (stage_done)
               state_next = S_OFF;
         end
         S_FAULT: begin
            if (fault_clr)
               state_next = S_OFF;
         end
         default: state_next = S_OFF;
      endcase

      cnt_next = (state_next != state_reg) ? 8'd0 :
                 (cnt_reg == 8'hFF)        ? cnt_reg : cnt_reg + 8'd1;

      // Outputs are decoded from the next state so they change on the same edge as state.
      iso_n_next = 1'b0;
      wb_en_next = 1'b0;
      la_en_next = 1'b0;
      ready_next = 1'b0;
      fault_next = 1'b0;
      case (state_next)
         S_ISO_REL: iso_n_next = 1'b1;
         S_WB_EN: begin
            iso_n_next = 1'b1;
            wb_en_next = 1'b1;
         end
         S_ON: begin
            iso_n_next = 1'b1;
            wb_en_next = 1'b1;
            la_en_next = 1'b1;
            ready_next = 1'b1;
         end
         S_SHDN_LA: begin
            iso_n_next = 1'b1;
            wb_en_next = 1'b1;
         end
         S_SHDN_WB: iso_n_next = 1'b1;
         S_FAULT:   fault_next = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg   <= S_OFF;
         cnt_reg     <= 8'd0;
         pg_meta_reg <= 1'b0;
         pg_sync_reg <= 1'b0;
         iso_n_reg   <= 1'b0;
         wb_en_reg   <= 1'b0;
         la_en_reg   <= 1'b0;
         ready_reg   <= 1'b0;
         fault_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pg_meta_reg <= pwr_good;
         pg_sync_reg <= pg_meta_reg;
         iso_n_reg   <= iso_n_next;
         wb_en_reg   <= wb_en_next;
         la_en_reg   <= la_en_next;
         ready_reg   <= ready_next;
         fault_reg   <= fault_next;
      end
   end

   assign mprj2_iso_n = iso_n_reg;
   assign mprj2_wb_en = wb_en_reg;
   assign mprj2_la_en = la_en_reg;
   assign mprj2_ready = ready_reg;
   assign fault       = fault_reg;
   assign state       = state_reg;

endmodule

// File: tb/tb_mprj2_power_sequencer.sv
// Directed bench for mprj2_power_sequencer: expectations are queued as stimulus is
// applied and popped against the DUT outputs {state, fault, ready, la_en, wb_en, iso_n}.
module tb_mprj2_power_sequencer;

   logic       clk;
   logic       rst;
   logic       pwr_good;
   logic       en_req;
   logic       fault_clr;
   logic       iso_n, wb_en, la_en, ready, fault;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];

   mprj2_power_sequencer dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .pwr_good    (pwr_good),
      .en_req      (en_req),
      .fault_clr   (fault_clr),
      .mprj2_iso_n (iso_n),
      .mprj2_wb_en (wb_en),
      .mprj2_la_en (la_en),
      .mprj2_ready (ready),
      .fault       (fault),
      .state       (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected output word per state, straight from the output table of each state.
   function automatic logic [7:0] model(input logic [2:0] st);
      logic [4:0] o;
      case (st)
         3'd2:    o = 5'b00001;
         3'd3:    o = 5'b00011;
         3'd4:    o = 5'b01111;
         3'd5:    o = 5'b00011;
         3'd6:    o = 5'b00001;
         3'd7:    o = 5'b10000;
         default: o = 5'b00000;
      endcase
      return {st, o};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic step(input string tag, input int n, input logic [2:0] st);
      exp_t e;
      logic [7:0] obs;
      e.tag = tag;
      e.val = model(st);
      sb.push_back(e);
      tick(n);
      e = sb.pop_front();
      obs = {state, fault, ready, la_en, wb_en, iso_n};
      n_cmp++;
      $display("step %-14s state=%0d iso=%b wb=%b la=%b rdy=%b flt=%b", e.tag, state,
               iso_n, wb_en, la_en, ready, fault);
      assert (obs === e.val) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
   endtask

   // Ordering invariants checked every cycle outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         n_cmp++;
         assert ((!ready || la_en) && (!la_en || wb_en) && (!wb_en || iso_n)) else begin
            n_bad++;
            $error("FAIL invariant observed=%b%b%b%b expected=ordered", ready, la_en, wb_en, iso_n);
         end
      end
   end

   initial begin
      rst = 1'b1;
      pwr_good = 1'b0;
      en_req = 1'b0;
      fault_clr = 1'b0;
      tick(2);
      step("reset", 0, 3'd0);

      // Power-up from reset release: 2-cycle sync latency, then debounce and stages.
      rst = 1'b0;
      pwr_good = 1'b1;
      en_req = 1'b1;
      step("sync_latency", 2, 3'd0);
      step("deb_entry", 1, 3'd1);
      step("deb_last", 15, 3'd1);
      step("iso_rel", 1, 3'd2);
      step("iso_hold", 3, 3'd2);
      step("wb_en", 1, 3'd3);
      step("on", 4, 3'd4);
      step("on_hold", 5, 3'd4);

      // Orderly shutdown; en_req re-raised mid-shutdown must not interrupt it.
      en_req = 1'b0;
      step("shdn_la", 1, 3'd5);
      step("shdn_la_hold", 3, 3'd5);
      step("shdn_wb", 1, 3'd6);
      en_req = 1'b1;
      step("shdn_wb_hold", 2, 3'd6);
      step("shdn_off", 2, 3'd0);
      step("re_debounce", 1, 3'd1);

      // One-cycle power-good glitch at debounce cycle 10.
      tick(10);
      pwr_good = 1'b0;
      tick(1);
      pwr_good = 1'b1;
      step("glitch_sync", 1, 3'd1);
      step("deb_abort", 1, 3'd0);
      step("deb_restart", 1, 3'd1);
      step("deb_full", 15, 3'd1);
      step("iso_rel2", 1, 3'd2);
      step("on2", 8, 3'd4);

      // Power loss in ON.
      pwr_good = 1'b0;
      step("loss_sync", 2, 3'd4);
      step("fault", 1, 3'd7);
      en_req = 1'b0;
      step("fault_en_lo", 2, 3'd7);
      en_req = 1'b1;
      step("fault_en_hi", 2, 3'd7);
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
      step("fault_clr", 0, 3'd0);
      step("off_no_pg", 3, 3'd0);

      // Simultaneous power loss and request drop in WB_EN; fault_clr ignored in ISO_REL.
      pwr_good = 1'b1;
      step("deb3", 3, 3'd1);
      step("iso_rel3", 16, 3'd2);
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
      step("clr_ignored", 0, 3'd2);
      step("wb_en3", 3, 3'd3);
      pwr_good = 1'b0;
      tick(2);
      en_req = 1'b0;
      step("pre_simul", 0, 3'd3);
      step("simul_fault", 1, 3'd7);
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
      step("fault_clr2", 0, 3'd0);

      // Asynchronous reset in WB_EN.
      pwr_good = 1'b1;
      en_req = 1'b1;
      step("wb_en4", 3 + 16 + 4, 3'd3);
      #2 rst = 1'b1;
      #1;
      step("async_rst", 0, 3'd0);
      tick(1);
      rst = 1'b0;
      en_req = 1'b0;
      step("post_rst", 3, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
